// File: rtl/lau_pkg.sv
// lau_pkg: shared types and helpers for the integer-log datapath and its request arbiter
package lau_pkg;

    typedef enum logic {SLOW, FAST} speed_t;

    typedef enum logic {EMPTY, FULL} rsp_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/Log2.sv
// Log2: combinational floor(log2(A)) via leading-one detection and index encoding; Z is 0 for A == 0
module Log2
    import lau_pkg::*;
#(
    parameter int     width = 8,
    parameter speed_t speed = FAST
) (
    input  logic [width-1:0]         i_a,
    output logic [$clog2(width)-1:0] o_z,
    output logic                     o_zero
);

    localparam int ZW = $clog2(width);

    assign o_zero = ~|i_a;

    generate
        if (speed == FAST) begin : g_fast
            // flat scan from LSB: the highest set bit overwrites last
            always_comb begin
                o_z = '0;
                for (int i = 0; i < width; i++)
                    if (i_a[i]) o_z = ZW'(i);
            end
        end else begin : g_slow
            logic w_found;
            // scan from MSB and stop at the first set bit
            always_comb begin
                o_z     = '0;
                w_found = 1'b0;
                for (int i = width - 1; i >= 0; i--)
                    if (i_a[i] && !w_found) begin
                        o_z     = ZW'(i);
                        w_found = 1'b1;
                    end
            end
        end
    endgenerate

endmodule

// File: rtl/log2_rr_arb.sv
// log2_rr_arb: picks the first requester at or above the pointer, falling back to the lowest requester; pointer 0 gives fixed priority
module log2_rr_arb
    import lau_pkg::*;
#(
    parameter int n_req = 4
) (
    input  logic [n_req-1:0]        i_req,
    input  logic [idx_w(n_req)-1:0] i_ptr,
    output logic [n_req-1:0]        o_gnt,
    output logic [idx_w(n_req)-1:0] o_idx
);

    localparam int IW = idx_w(n_req);

    // lowest requester overall, overridden by the lowest one at or above the pointer
    always_comb begin
        o_idx = '0;
        for (int i = n_req - 1; i >= 0; i--)
            if (i_req[i]) o_idx = IW'(i);
        for (int i = n_req - 1; i >= 0; i--)
            if (i_req[i] && IW'(i) >= i_ptr) o_idx = IW'(i);
        o_gnt        = '0;
        o_gnt[o_idx] = |i_req;
    end

endmodule

// File: rtl/log2_share_arb.sv
// log2_share_arb: shares one Log2 unit among n_req valid/ready requesters with a one-entry tagged response register.
// Define LOG2_ARB_RR_EN for round-robin arbitration; otherwise the lowest valid index always wins.
module log2_share_arb
    import lau_pkg::*;
#(
    parameter int     width = 8,
    parameter speed_t speed = FAST,
    parameter int     n_req = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [n_req-1:0]             req_valid_i,
    input  logic [n_req-1:0][width-1:0]  req_a_i,
    output logic [n_req-1:0]             req_ready_o,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [$clog2(width)-1:0]     rsp_z_o,
    output logic                         rsp_zero_o,
    output logic [$clog2(n_req)-1:0]     rsp_id_o
);

    localparam int ZW = $clog2(width);
    localparam int IW = idx_w(n_req);

    typedef struct packed {
        logic [ZW-1:0] z;
        logic          zero;
        logic [IW-1:0] id;
    } log2_rsp_t;

    rsp_state_t       r_state, w_state_nxt;
    log2_rsp_t        r_rsp;
    logic [n_req-1:0] w_gnt;
    logic [IW-1:0]    w_idx, w_ptr;
    logic [width-1:0] w_a;
    logic [ZW-1:0]    w_z;
    logic             w_zero, w_free, w_hs;

`ifdef LOG2_ARB_RR_EN
    logic [IW-1:0] r_ptr;

    // pointer moves one past the winner after every grant
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) r_ptr <= '0;
        else if (w_hs) r_ptr <= (w_idx == IW'(n_req - 1)) ? '0 : w_idx + IW'(1);

    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    log2_rr_arb #(.n_req(n_req)) u_arb (
        .i_req (req_valid_i),
        .i_ptr (w_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    // slot can take a result when empty or being popped this cycle; no grants while in reset
    assign w_free      = (r_state == EMPTY) || rsp_ready_i;
    assign req_ready_o = (rst_ni && w_free) ? w_gnt : '0;
    assign w_hs        = |req_ready_o;
    assign w_a         = req_a_i[w_idx];

    Log2 #(.width(width), .speed(speed)) u_log2 (
        .i_a    (w_a),
        .o_z    (w_z),
        .o_zero (w_zero)
    );

    // response slot occupancy
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) r_state <= EMPTY;
        else r_state <= w_state_nxt;

    // a grant always fills the slot; otherwise a pop empties it, a stall holds it
    always_comb w_state_nxt = w_hs ? FULL : (rsp_ready_i ? EMPTY : r_state);

    // valid mirrors occupancy
    always_comb rsp_valid_o = (r_state == FULL);

    // capture result and requester tag on a handshake
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) r_rsp <= '0;
        else if (w_hs) r_rsp <= '{z: w_z, zero: w_zero, id: w_idx};

    assign rsp_z_o    = r_rsp.z;
    assign rsp_zero_o = r_rsp.zero;
    assign rsp_id_o   = r_rsp.id;

endmodule

// File: tb/tb_log2_share_arb.sv
// tb_log2_share_arb: randomized and directed checks of log2_share_arb against a transaction-level model
module tb_log2_share_arb;
    import lau_pkg::*;

`ifdef LOG2_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [3:0]      req_valid_i;
    logic [3:0][7:0] req_a_i;
    logic [3:0]      req_ready_o;
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [2:0]      rsp_z_o;
    logic            rsp_zero_o;
    logic [1:0]      rsp_id_o;

    log2_share_arb #(.width(8), .speed(FAST), .n_req(4)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_a_i     (req_a_i),
        .req_ready_o (req_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_z_o     (rsp_z_o),
        .rsp_zero_o  (rsp_zero_o),
        .rsp_id_o    (rsp_id_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    bit       pend [4];
    bit [7:0] op   [4];
    bit       m_valid, m_zero;
    int       m_z, m_id, m_ptr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ref_log2(input int a);
        int r = 0;
        for (int b = 0; b < 8; b++) if (a >= (1 << b)) r = b;
        return r;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_zero = 0; m_z = 0; m_id = 0; m_ptr = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req_valid_i[i] = pend[i];
            req_a_i[i]     = op[i];
        end
    endtask

    // one cycle: called just after a falling edge, returns at the next falling edge
    task automatic step(input bit refill);
        logic [3:0] g;
        int id, j;
        drive();
        #1;
        g  = '0;
        id = -1;
        if (!m_valid || rsp_ready_i)
            for (int k = 0; k < 4; k++) begin
                j = RR ? (m_ptr + k) % 4 : k;
                if (pend[j] && id < 0) id = j;
            end
        if (id >= 0) g[id] = 1'b1;
        chk("req_ready", req_ready_o, g);
        @(posedge clk_i);
        #1;
        if (id >= 0) begin
            m_valid = 1;
            m_z     = ref_log2(op[id]);
            m_zero  = (op[id] == 0);
            m_id    = id;
            m_ptr   = (id + 1) % 4;
            pend[id] = refill;
            op[id]   = 8'($urandom);
        end else if (rsp_ready_i) m_valid = 0;
        chk("rsp_valid", rsp_valid_o, m_valid);
        if (m_valid) begin
            chk("rsp_z", rsp_z_o, m_z);
            chk("rsp_zero", rsp_zero_o, m_zero);
            chk("rsp_id", rsp_id_o, m_id);
        end
        @(negedge clk_i);
    endtask

    initial begin
        int exp_ids [5];
        logic [2:0] hold_z;
        exp_ids = RR ? '{0, 1, 2, 3, 0} : '{0, 0, 0, 0, 0};
        model_reset();
        rst_ni      = 1'b0;
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin pend[i] = 1; op[i] = 8'($urandom); end
        drive();
        repeat (2) @(negedge clk_i);
        #1;
        chk("reset_ready", req_ready_o, 4'h0);
        chk("reset_valid", rsp_valid_o, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // fairness: all four stay valid
        for (int n = 0; n < 5; n++) begin
            step(1);
            chk("fair_id", rsp_id_o, exp_ids[n]);
        end

        // drain
        for (int i = 0; i < 4; i++) pend[i] = 0;
        repeat (2) step(0);
        chk("drained", rsp_valid_o, 1'b0);

        // single request
        pend[2] = 1; op[2] = 8'h16;
        step(0);
        chk("single_z", rsp_z_o, 3'd4);
        chk("single_id", rsp_id_o, 2'd2);
        chk("single_zero", rsp_zero_o, 1'b0);

        // zero operand and top bit
        pend[1] = 1; op[1] = 8'h00;
        step(0);
        chk("zero_z", rsp_z_o, 3'd0);
        chk("zero_flag", rsp_zero_o, 1'b1);
        chk("zero_id", rsp_id_o, 2'd1);
        pend[3] = 1; op[3] = 8'h80;
        step(0);
        chk("msb_z", rsp_z_o, 3'd7);

        // back-pressure then pop+refill with no bubble
        rsp_ready_i = 1'b0;
        pend[0] = 1; op[0] = 8'h05;
        hold_z = rsp_z_o;
        repeat (3) step(0);
        chk("stall_z", rsp_z_o, hold_z);
        chk("stall_id", rsp_id_o, 2'd3);
        rsp_ready_i = 1'b1;
        step(0);
        chk("refill_valid", rsp_valid_o, 1'b1);
        chk("refill_id", rsp_id_o, 2'd0);
        chk("refill_z", rsp_z_o, 3'd2);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++)
                if (!pend[i] && $urandom_range(1, 0) == 1) begin
                    pend[i] = 1;
                    op[i]   = ($urandom_range(7, 0) == 0) ? 8'h00 : 8'($urandom);
                end
            rsp_ready_i = ($urandom_range(3, 0) != 0);
            step(0);
        end

        // asynchronous reset while FULL
        for (int i = 0; i < 4; i++) pend[i] = 0;
        rsp_ready_i = 1'b1;
        step(0);
        pend[2] = 1; op[2] = 8'h3C;
        rsp_ready_i = 1'b0;
        step(0);
        chk("pre_reset_full", rsp_valid_o, 1'b1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_valid", rsp_valid_o, 1'b0);
        chk("async_ready", req_ready_o, 4'h0);
        model_reset();
        pend[2] = 0;
        @(negedge clk_i);
        rst_ni      = 1'b1;
        rsp_ready_i = 1'b1;
        repeat (2) step(0);
        chk("post_reset_valid", rsp_valid_o, 1'b0);
        pend[3] = 1; op[3] = 8'h09;
        step(0);
        chk("post_reset_id", rsp_id_o, 2'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
